// File: rtl/machine_ctrl.sv
// machine_ctrl: 8-step instruction-cycle sequencer for the 8-bit accumulator CPU.
// Define MACHINE_CTRL_INSTR_CNT_EN to add the retired-instruction counter (CNT_W, instr_cnt_o).
module machine_ctrl #(
  parameter int STEPS = 8
`ifdef MACHINE_CTRL_INSTR_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic [2:0]       opcode_i,
  input  logic             zero_i,
  input  logic             resume_i,
  output logic             inc_pc_o,
  output logic             load_pc_o,
  output logic             load_acc_o,
  output logic             load_ir_o,
  output logic             rd_o,
  output logic             wr_o,
  output logic             datactl_ena_o,
  output logic             halt_o
`ifdef MACHINE_CTRL_INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt_o
`endif
);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;
  localparam logic [2:0] S6 = 3'd6;
  localparam logic [2:0] S7 = 3'd7;
  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic load_ir;
    logic rd;
    logic wr;
    logic datactl_ena;
  } strobes_t;

  logic [2:0] step_q, step_d;
  logic       halt_q, halt_d;
  strobes_t   strb_q, strb_d, decode;
  logic       alu_mem, skip;

  assign alu_mem = opcode_i inside {OP_ADD, OP_ANDD, OP_XORR, OP_LDA};
  assign skip    = (opcode_i == OP_SKZ) && zero_i;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    decode = '0;
    case (step_q)
      S0: begin
        decode.rd      = 1'b1;
        decode.load_ir = 1'b1;
      end
      S1: begin
        decode.rd      = 1'b1;
        decode.load_ir = 1'b1;
        decode.inc_pc  = 1'b1;
      end
      S2: ;
      S3: decode.inc_pc = 1'b1;
      S4: begin
        decode.rd          = alu_mem;
        decode.load_pc     = (opcode_i == OP_JMP);
        decode.datactl_ena = (opcode_i == OP_STO);
      end
      S5: begin
        decode.rd          = alu_mem;
        decode.load_acc    = alu_mem;
        decode.inc_pc      = skip || (opcode_i == OP_JMP);
        decode.load_pc     = (opcode_i == OP_JMP);
        decode.wr          = (opcode_i == OP_STO);
        decode.datactl_ena = (opcode_i == OP_STO);
      end
      S6: begin
        decode.rd          = alu_mem;
        decode.datactl_ena = (opcode_i == OP_STO);
      end
      S7: decode.inc_pc = skip;
      default: ;
    endcase
  end

  // Halted wins over ena; a pause freezes the step but drops every strobe.
  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
    strb_d = '0;
    if (halt_q) begin
      step_d = S0;
      if (resume_i) halt_d = 1'b0;
    end else if (ena_i) begin
      strb_d = decode;
      step_d = (step_q == LAST_STEP) ? S0 : step_q + 3'd1;
      if (step_q == S3 && opcode_i == OP_HLT) halt_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q <= S0;
      halt_q <= 1'b0;
      strb_q <= '0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
      strb_q <= strb_d;
    end
  end

  assign inc_pc_o      = strb_q.inc_pc;
  assign load_pc_o     = strb_q.load_pc;
  assign load_acc_o    = strb_q.load_acc;
  assign load_ir_o     = strb_q.load_ir;
  assign rd_o          = strb_q.rd;
  assign wr_o          = strb_q.wr;
  assign datactl_ena_o = strb_q.datactl_ena;
  assign halt_o        = halt_q;

`ifdef MACHINE_CTRL_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  // An instruction retires on its last step, or on the S3 edge of HLT.
  assign retire = !halt_q && ena_i &&
                  ((step_q == LAST_STEP) || (step_q == S3 && opcode_i == OP_HLT));

  always_ff @(posedge clk_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_machine_ctrl.sv
// tb_machine_ctrl: directed and randomized stimulus for machine_ctrl, compared every
// edge against a table-driven reference of the instruction cycle.
module tb_machine_ctrl;

  logic       clk = 1'b0;
  logic       rst, ena, zero, resume;
  logic [2:0] opcode;
  logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
`ifdef MACHINE_CTRL_INSTR_CNT_EN
  logic [15:0] instr_cnt;
`endif

  machine_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ena_i         (ena),
    .opcode_i      (opcode),
    .zero_i        (zero),
    .resume_i      (resume),
    .inc_pc_o      (inc_pc),
    .load_pc_o     (load_pc),
    .load_acc_o    (load_acc),
    .load_ir_o     (load_ir),
    .rd_o          (rd),
    .wr_o          (wr),
    .datactl_ena_o (datactl_ena),
    .halt_o        (halt)
`ifdef MACHINE_CTRL_INSTR_CNT_EN
    ,
    .instr_cnt_o   (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output bit positions in the packed observation vector.
  localparam logic [7:0] INC  = 8'h80;
  localparam logic [7:0] LPC  = 8'h40;
  localparam logic [7:0] LACC = 8'h20;
  localparam logic [7:0] IR   = 8'h10;
  localparam logic [7:0] RD   = 8'h08;
  localparam logic [7:0] WR   = 8'h04;
  localparam logic [7:0] DCTL = 8'h02;
  localparam logic [7:0] HLT  = 8'h01;

  int n_vec = 0;
  int n_err = 0;

  // Reference: per-opcode, per-zero, per-step strobe table plus a few state variables.
  logic [7:0]  tbl [8][2][8];
  int          m_step;
  bit          m_halted;
  logic [7:0]  m_out;
  int unsigned m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic build_table();
    for (int op = 0; op < 8; op++) begin
      for (int z = 0; z < 2; z++) begin
        for (int s = 0; s < 8; s++) tbl[op][z][s] = 8'h00;
        tbl[op][z][0] = RD | IR;
        tbl[op][z][1] = RD | IR | INC;
        tbl[op][z][3] = INC;
        case (op)
          0: tbl[op][z][3] = INC | HLT;
          1: if (z == 1) begin
               tbl[op][z][5] = INC;
               tbl[op][z][7] = INC;
             end
          2, 3, 4, 5: begin
               tbl[op][z][4] = RD;
               tbl[op][z][5] = RD | LACC;
               tbl[op][z][6] = RD;
             end
          6: begin
               tbl[op][z][4] = DCTL;
               tbl[op][z][5] = WR | DCTL;
               tbl[op][z][6] = DCTL;
             end
          default: begin
               tbl[op][z][4] = LPC;
               tbl[op][z][5] = INC | LPC;
             end
        endcase
      end
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_step = 0; m_halted = 0; m_out = 8'h00; m_cnt = 0;
    end else if (m_halted) begin
      m_step = 0;
      if (resume) begin
        m_halted = 0; m_out = 8'h00;
      end else begin
        m_out = HLT;
      end
    end else if (!ena) begin
      m_out = 8'h00;
    end else begin
      m_out = tbl[opcode][zero][m_step];
      if (m_step == 3 && opcode == 3'd0) begin
        m_halted = 1; m_cnt++;
      end
      if (m_step == 7) m_cnt++;
      m_step = (m_step + 1) % 8;
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [2:0] op,
                       input logic z, input logic rs);
    rst = r; ena = e; opcode = op; zero = z; resume = rs;
    @(posedge clk);
    model_edge();
    #1;
    check("strobes", {24'd0, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt},
          {24'd0, m_out});
    check("rd_wr_excl", {31'd0, rd & wr}, 32'd0);
`ifdef MACHINE_CTRL_INSTR_CNT_EN
    check("instr_cnt", {16'd0, instr_cnt}, {16'd0, m_cnt[15:0]});
`endif
  endtask

  initial begin
    int pulses;
    build_table();
    m_step = 0; m_halted = 0; m_out = 8'h00; m_cnt = 0;

    // Reset with ena high, then a full LDA and STO cycle.
    repeat (2) cycle(1, 1, 3'b101, 0, 0);
    repeat (8) cycle(0, 1, 3'b101, 0, 0);
    repeat (8) cycle(0, 1, 3'b110, 0, 0);

    // SKZ: four inc_pc pulses when zero, two otherwise.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 3'b001, 1, 0);
      pulses += int'(inc_pc);
    end
    check("skz_zero_pulses", pulses, 4);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 3'b001, 0, 0);
      pulses += int'(inc_pc);
    end
    check("skz_nonzero_pulses", pulses, 2);

    // JMP with a three-edge pause after S3.
    repeat (4) cycle(0, 1, 3'b111, 0, 0);
    repeat (3) cycle(0, 0, 3'b111, 0, 0);
    cycle(0, 1, 3'b111, 0, 0);
    check("jmp_s4_load_pc", {31'd0, load_pc}, 32'd1);
    repeat (3) cycle(0, 1, 3'b111, 0, 0);

    // HLT, hold for ten edges, ignored resume-free pause, resume, refetch.
    repeat (4) cycle(0, 1, 3'b000, 0, 0);
    check("hlt_enter", {31'd0, halt}, 32'd1);
    repeat (10) cycle(0, 1, 3'b000, 0, 0);
    cycle(0, 1, 3'b000, 0, 1);
    check("hlt_resume", {31'd0, halt}, 32'd0);
    repeat (8) cycle(0, 1, 3'b101, 0, 0);

    // Resume while running is ignored; reset mid-halt clears it.
    repeat (4) cycle(0, 1, 3'b000, 0, 1);
    repeat (3) cycle(0, 1, 3'b000, 0, 0);
    cycle(1, 1, 3'b000, 0, 0);
    repeat (8) cycle(0, 1, 3'b010, 0, 0);

    // Randomized traffic, including mid-cycle opcode changes.
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 9) != 0),
            3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            logic'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
